// File: rtl/mandel_sched_pkg.sv
// Shared types and helpers for the Mandelbrot frame scheduler: FSM states,
// pixel tag / FIFO entry layouts and the round-robin pick used on both sides.
package mandel_sched_pkg;

    localparam int unsigned MAX_ENG     = 16;
    localparam int unsigned TAG_XY_W    = 16;
    localparam int unsigned MAX_COLOR_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic [TAG_XY_W-1:0] x;
        logic [TAG_XY_W-1:0] y;
    } pix_tag_t;

    typedef struct packed {
        pix_tag_t               tag;
        logic [MAX_COLOR_W-1:0] color;
    } fifo_entry_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] idx;
    } rr_grant_t;

    function automatic int unsigned xw_of(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    function automatic int unsigned yw_of(input int unsigned height);
        return (height > 1) ? $clog2(height) : 1;
    endfunction

    // Search starts one past the previous grant so every requester is served in turn.
    function automatic rr_grant_t rr_pick(input logic [MAX_ENG-1:0] req,
                                          input logic [3:0]         last,
                                          input int unsigned        n);
        rr_grant_t   g;
        int unsigned j;
        logic [3:0]  jj;
        g = '0;
        for (int unsigned k = 1; k <= MAX_ENG; k++) begin
            if (k <= n) begin
                j  = (32'(last) + k) % n;
                jj = 4'(j);
                if (!g.valid && req[jj]) begin
                    g.valid = 1'b1;
                    g.idx   = jj;
                end
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/mandel_pix_fifo.sv
// Generic show-ahead synchronous FIFO; head is presented combinationally and
// reads as zero while empty.
module mandel_pix_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 8
) (
    input  logic         sysclk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          do_push, do_pop;

    always_comb begin
        full    = (count == CW'(DEPTH));
        empty   = (count == '0);
        do_push = push && !full;
        do_pop  = pop && !empty;
        dout    = empty ? '0 : mem[rd_ptr];
    end

    always_ff @(posedge sysclk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge sysclk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mandel_frame_scheduler.sv
// Raster walker that farms pixels out to N depth engines, gathers results in
// completion order and streams tagged colours to the framebuffer writer.
module mandel_frame_scheduler
    import mandel_sched_pkg::*;
#(
    parameter int unsigned N_ENGINES  = 4,
    parameter int unsigned WIDTH      = 640,
    parameter int unsigned HEIGHT     = 480,
    parameter int unsigned COORD_W    = 32,
    parameter int unsigned COLOR_W    = 24,
    parameter int unsigned FIFO_DEPTH = 8,
    localparam int unsigned XW = xw_of(WIDTH),
    localparam int unsigned YW = yw_of(HEIGHT)
) (
    input  logic                         sysclk,
    input  logic                         reset,
    input  logic                         frame_start,
    input  logic signed [COORD_W-1:0]    re_origin,
    input  logic signed [COORD_W-1:0]    im_origin,
    input  logic signed [COORD_W-1:0]    step,
    output logic                         busy,
    output logic                         frame_done,
    output logic [N_ENGINES-1:0]         eng_start,
    output logic [XW-1:0]                eng_x,
    output logic [YW-1:0]                eng_y,
    output logic signed [COORD_W-1:0]    eng_re_c,
    output logic signed [COORD_W-1:0]    eng_im_c,
    input  logic [N_ENGINES-1:0]         eng_done,
    input  logic [N_ENGINES*COLOR_W-1:0] eng_color,
    output logic                         pix_valid,
    input  logic                         pix_ready,
    output logic [XW-1:0]                pix_x,
    output logic [YW-1:0]                pix_y,
    output logic [COLOR_W-1:0]           pix_color
);

    localparam int unsigned TOTAL = WIDTH * HEIGHT;
    localparam int unsigned PCW   = $clog2(TOTAL + 1);
    localparam int unsigned FE_W  = $bits(fifo_entry_t);

    state_t                    state, state_nxt;
    logic [XW-1:0]             x;
    logic [YW-1:0]             y;
    logic signed [COORD_W-1:0] re_acc, im_acc, re_org, step_r;
    logic [N_ENGINES-1:0]      eng_busy, slot_full, free_vec, cap_vec, disp_vec, coll_vec;
    logic [COLOR_W-1:0]        slot_color [N_ENGINES];
    pix_tag_t                  tags [N_ENGINES];
    logic [3:0]                disp_last, coll_last;
    rr_grant_t                 disp_g, coll_g;
    logic                      dispatch, collect, last_pix, pop;
    logic [PCW-1:0]            pop_cnt;
    fifo_entry_t               push_entry, head_entry;
    logic                      fifo_full, fifo_empty;
    logic                      unused_head;

    always_comb begin
        free_vec = ~eng_busy & ~slot_full;
        cap_vec  = eng_done & eng_busy;
        disp_g   = rr_pick(MAX_ENG'(free_vec), disp_last, N_ENGINES);
        coll_g   = rr_pick(MAX_ENG'(slot_full), coll_last, N_ENGINES);
        dispatch = (state == RUN) && disp_g.valid;
        collect  = !fifo_full && coll_g.valid;
        last_pix = (x == XW'(WIDTH - 1)) && (y == YW'(HEIGHT - 1));
        pop      = !fifo_empty && pix_ready;
        disp_vec   = '0;
        coll_vec   = '0;
        push_entry = '0;
        for (int unsigned i = 0; i < N_ENGINES; i++) begin
            disp_vec[i] = dispatch && (disp_g.idx == 4'(i));
            coll_vec[i] = collect && (coll_g.idx == 4'(i));
            if (coll_vec[i]) begin
                push_entry.tag   = tags[i];
                push_entry.color = MAX_COLOR_W'(slot_color[i]);
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        busy       = (state == RUN) || (state == DRAIN);
        frame_done = (state == DONE);
        case (state)
            IDLE:    if (frame_start) state_nxt = RUN;
            RUN:     if (dispatch && last_pix) state_nxt = DRAIN;
            DRAIN:   if (pop && (pop_cnt == PCW'(TOTAL - 1))) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (!reset) begin
            state     <= IDLE;
            x         <= '0;
            y         <= '0;
            re_acc    <= '0;
            im_acc    <= '0;
            re_org    <= '0;
            step_r    <= '0;
            eng_busy  <= '0;
            slot_full <= '0;
            pop_cnt   <= '0;
            disp_last <= 4'(N_ENGINES - 1);
            coll_last <= 4'(N_ENGINES - 1);
        end else begin
            state <= state_nxt;
            if (state == IDLE && frame_start) begin
                x       <= '0;
                y       <= '0;
                re_acc  <= re_origin;
                im_acc  <= im_origin;
                re_org  <= re_origin;
                step_r  <= step;
                pop_cnt <= '0;
            end else if (dispatch) begin
                if (x == XW'(WIDTH - 1)) begin
                    x      <= '0;
                    y      <= (y == YW'(HEIGHT - 1)) ? '0 : y + YW'(1);
                    re_acc <= re_org;
                    im_acc <= im_acc - step_r;
                end else begin
                    x      <= x + XW'(1);
                    re_acc <= re_acc + step_r;
                end
            end
            if (pop && busy) pop_cnt <= pop_cnt + PCW'(1);
            // Completion and redispatch never collide: a busy engine is never free.
            eng_busy  <= (eng_busy & ~cap_vec) | disp_vec;
            slot_full <= (slot_full & ~coll_vec) | cap_vec;
            if (dispatch) disp_last <= disp_g.idx;
            if (collect)  coll_last <= coll_g.idx;
        end
    end

    always_ff @(posedge sysclk) begin
        for (int unsigned i = 0; i < N_ENGINES; i++) begin
            if (cap_vec[i])  slot_color[i] <= eng_color[i*COLOR_W +: COLOR_W];
            if (disp_vec[i]) tags[i]       <= '{x: TAG_XY_W'(x), y: TAG_XY_W'(y)};
        end
    end

    mandel_pix_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (FE_W)
    ) u_fifo (
        .sysclk (sysclk),
        .reset  (reset),
        .push   (collect),
        .din    (push_entry),
        .pop    (pop),
        .dout   (head_entry),
        .empty  (fifo_empty),
        .full   (fifo_full)
    );

    assign eng_start   = disp_vec;
    assign eng_x       = x;
    assign eng_y       = y;
    assign eng_re_c    = re_acc;
    assign eng_im_c    = im_acc;
    assign pix_valid   = !fifo_empty;
    assign pix_x       = head_entry.tag.x[XW-1:0];
    assign pix_y       = head_entry.tag.y[YW-1:0];
    assign pix_color   = head_entry.color[COLOR_W-1:0];
    assign unused_head = ^head_entry;

endmodule

// File: tb/tb_mandel_frame_scheduler.sv
// Directed bench for mandel_frame_scheduler on a 4x3 frame with two modelled
// fixed-latency engines and a 4-entry output FIFO.
module tb_mandel_frame_scheduler;

    logic        sysclk = 1'b0;
    logic        reset = 1'b0;
    logic        frame_start = 1'b0;
    logic [31:0] re_origin = '0, im_origin = '0, step = '0;
    logic        busy, frame_done;
    logic [1:0]  eng_start;
    logic [1:0]  eng_x, eng_y;
    logic [31:0] eng_re_c, eng_im_c;
    logic [1:0]  eng_done = '0;
    logic [47:0] eng_color = '0;
    logic        pix_valid;
    logic        pix_ready = 1'b1;
    logic [1:0]  pix_x, pix_y;
    logic [23:0] pix_color;

    int checks = 0;
    int failures = 0;

    int          lat [2];
    logic        pend [2];
    int          rem [2];
    logic [23:0] ecol [2];
    int          cyc = 0;
    int          seen [4][4];
    logic [31:0] disp_re [4][4];
    logic [31:0] disp_im [4][4];
    int          disp_cnt = 0, pop_total = 0, color_errs = 0, start_busy_errs = 0;
    int          fd_cnt = 0;
    bit          both_done = 0;
    int          pop_xq [$];
    int          pop_yq [$];
    int          pop_cq [$];

    mandel_frame_scheduler #(
        .N_ENGINES  (2),
        .WIDTH      (4),
        .HEIGHT     (3),
        .COORD_W    (32),
        .COLOR_W    (24),
        .FIFO_DEPTH (4)
    ) dut (
        .sysclk      (sysclk),
        .reset       (reset),
        .frame_start (frame_start),
        .re_origin   (re_origin),
        .im_origin   (im_origin),
        .step        (step),
        .busy        (busy),
        .frame_done  (frame_done),
        .eng_start   (eng_start),
        .eng_x       (eng_x),
        .eng_y       (eng_y),
        .eng_re_c    (eng_re_c),
        .eng_im_c    (eng_im_c),
        .eng_done    (eng_done),
        .eng_color   (eng_color),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_color   (pix_color)
    );

    always #5 sysclk = ~sysclk;

    function automatic logic [23:0] colorf(input logic [1:0] px, input logic [1:0] py);
        return 24'hA50003 + (24'(px) << 12) + (24'(py) << 4);
    endfunction

    function automatic int bad_pixels();
        int b = 0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (seen[i][j] != ((j < 3) ? 1 : 0)) b++;
        return b;
    endfunction

    // Engine models and output monitor, evaluated on the falling edge.
    always @(negedge sysclk) begin
        cyc++;
        eng_done = '0;
        if (!reset) begin
            pend[0] = 1'b0;
            pend[1] = 1'b0;
        end else begin
            if (frame_start && !busy) begin
                for (int i = 0; i < 4; i++)
                    for (int j = 0; j < 4; j++) seen[i][j] = 0;
                disp_cnt = 0; pop_total = 0; color_errs = 0; start_busy_errs = 0;
                fd_cnt = 0; both_done = 0;
                pop_xq.delete(); pop_yq.delete(); pop_cq.delete();
            end
            for (int i = 0; i < 2; i++) begin
                if (pend[i]) begin
                    if (rem[i] == 0) begin
                        eng_done[i] = 1'b1;
                        eng_color[i*24 +: 24] = ecol[i];
                        pend[i] = 1'b0;
                    end else begin
                        rem[i]--;
                    end
                end
            end
            if (eng_done == 2'b11) both_done = 1;
            for (int i = 0; i < 2; i++) begin
                if (eng_start[i]) begin
                    if (pend[i] || eng_done[i]) start_busy_errs++;
                    pend[i] = 1'b1;
                    rem[i]  = lat[i] - 1;
                    ecol[i] = colorf(eng_x, eng_y);
                    disp_cnt++;
                    disp_re[eng_x][eng_y] = eng_re_c;
                    disp_im[eng_x][eng_y] = eng_im_c;
                end
            end
            if (pix_valid && pix_ready) begin
                if (pix_color !== colorf(pix_x, pix_y)) color_errs++;
                seen[pix_x][pix_y]++;
                pop_total++;
                pop_xq.push_back(int'(pix_x));
                pop_yq.push_back(int'(pix_y));
                pop_cq.push_back(cyc);
            end
            if (frame_done) fd_cnt++;
        end
    end

    task automatic do_reset();
        @(posedge sysclk); #1;
        reset = 1'b0;
        frame_start = 1'b0;
        pix_ready = 1'b1;
        repeat (2) @(posedge sysclk);
        #1 reset = 1'b1;
    endtask

    task automatic start_frame(input logic [31:0] r, input logic [31:0] i, input logic [31:0] s);
        @(posedge sysclk); #1;
        frame_start = 1'b1; re_origin = r; im_origin = i; step = s;
        @(posedge sysclk); #1;
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input int maxc, output bit to);
        to = 1;
        for (int k = 0; k < maxc; k++) begin
            @(posedge sysclk); #1;
            if (fd_cnt > 0) begin
                to = 0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        lat[0] = 5; lat[1] = 5;
        repeat (3) @(posedge sysclk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b want 0", busy); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done: got %0b want 0", frame_done); end
        checks++; if (eng_start !== 2'b00) begin failures++; $display("FAIL reset_eng_start: got %0b want 0", eng_start); end
        checks++; if ({eng_x, eng_y, eng_re_c, eng_im_c} !== '0) begin failures++;
            $display("FAIL reset_eng_bus: got x=%0d y=%0d re=%h im=%h want all 0", eng_x, eng_y, eng_re_c, eng_im_c); end
        checks++; if ({pix_valid, pix_x, pix_y, pix_color} !== '0) begin failures++;
            $display("FAIL reset_pix: got v=%0b x=%0d y=%0d c=%h want all 0", pix_valid, pix_x, pix_y, pix_color); end
        reset = 1'b1;
    endtask

    task automatic test_basic_frame();
        bit to;
        do_reset();
        lat[0] = 5; lat[1] = 5;
        start_frame(32'h1000_0000, 32'h0, 32'h0100_0000);
        checks++; if (eng_start !== 2'b01) begin failures++; $display("FAIL basic_first_start: got %b want 01", eng_start); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy: got %0b want 1", busy); end
        checks++; if (eng_re_c !== 32'h1000_0000) begin failures++; $display("FAIL basic_first_re: got %h want 10000000", eng_re_c); end
        wait_done(500, to);
        checks++; if (to) begin failures++; $display("FAIL basic_timeout: got no frame_done want frame_done"); end
        checks++; if (bad_pixels() != 0) begin failures++; $display("FAIL basic_pixels: got %0d bad tags want 0", bad_pixels()); end
        checks++; if (color_errs != 0) begin failures++; $display("FAIL basic_colors: got %0d wrong want 0", color_errs); end
        checks++; if (disp_re[3][2] !== 32'h1300_0000) begin failures++; $display("FAIL basic_re_3_2: got %h want 13000000", disp_re[3][2]); end
        checks++; if (disp_im[3][2] !== 32'hFE00_0000) begin failures++; $display("FAIL basic_im_3_2: got %h want fe000000", disp_im[3][2]); end
        checks++; if (disp_re[1][1] !== 32'h1100_0000) begin failures++; $display("FAIL basic_re_1_1: got %h want 11000000", disp_re[1][1]); end
        checks++; if (disp_im[1][1] !== 32'hFF00_0000) begin failures++; $display("FAIL basic_im_1_1: got %h want ff000000", disp_im[1][1]); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_after: got %0b want 0", busy); end
        repeat (10) @(posedge sysclk);
        #1;
        checks++; if (fd_cnt != 1) begin failures++; $display("FAIL basic_done_pulses: got %0d want 1", fd_cnt); end
        checks++; if (start_busy_errs != 0) begin failures++; $display("FAIL basic_start_busy: got %0d want 0", start_busy_errs); end
    endtask

    task automatic test_out_of_order();
        bit to;
        do_reset();
        lat[0] = 3; lat[1] = 11;
        start_frame(32'h1000_0000, 32'h0, 32'h0100_0000);
        wait_done(800, to);
        checks++; if (to) begin failures++; $display("FAIL ooo_timeout: got no frame_done want frame_done"); end
        checks++; if (pop_xq.size() < 3 || pop_xq[1] != 2 || pop_yq[1] != 0) begin failures++;
            $display("FAIL ooo_second_pop: got n=%0d want (2,0) second", pop_xq.size()); end
        checks++; if (pop_xq.size() < 3 || pop_xq[2] != 1 || pop_yq[2] != 0) begin failures++;
            $display("FAIL ooo_third_pop: got n=%0d want (1,0) third", pop_xq.size()); end
        checks++; if (bad_pixels() != 0) begin failures++; $display("FAIL ooo_pixels: got %0d bad tags want 0", bad_pixels()); end
        checks++; if (color_errs != 0) begin failures++; $display("FAIL ooo_colors: got %0d wrong want 0", color_errs); end
    endtask

    task automatic test_backpressure();
        bit to;
        int pt, hold_errs;
        logic [1:0]  hx, hy;
        logic [23:0] hc;
        do_reset();
        lat[0] = 5; lat[1] = 5;
        start_frame(32'h1000_0000, 32'h0, 32'h0100_0000);
        for (int k = 0; k < 200; k++) begin
            if (pop_total >= 3) break;
            @(posedge sysclk); #1;
        end
        pix_ready = 1'b0;
        pt = pop_total;
        hx = pix_x; hy = pix_y; hc = pix_color;
        hold_errs = 0;
        repeat (40) begin
            @(posedge sysclk); #1;
            if (pix_valid !== 1'b1 || pix_x !== hx || pix_y !== hy || pix_color !== hc) hold_errs++;
        end
        checks++; if (pt != 3) begin failures++; $display("FAIL bp_pops_before: got %0d want 3", pt); end
        checks++; if (hold_errs != 0) begin failures++; $display("FAIL bp_hold: got %0d unstable cycles want 0", hold_errs); end
        checks++; if (pop_total != pt) begin failures++; $display("FAIL bp_no_pop: got %0d want %0d", pop_total, pt); end
        checks++; if (disp_cnt != 9) begin failures++; $display("FAIL bp_dispatch_stall: got %0d want 9", disp_cnt); end
        checks++; if (eng_start !== 2'b00) begin failures++; $display("FAIL bp_eng_start: got %b want 00", eng_start); end
        pix_ready = 1'b1;
        wait_done(800, to);
        checks++; if (to) begin failures++; $display("FAIL bp_timeout: got no frame_done want frame_done"); end
        checks++; if (bad_pixels() != 0) begin failures++; $display("FAIL bp_pixels: got %0d bad tags want 0", bad_pixels()); end
        checks++; if (color_errs != 0) begin failures++; $display("FAIL bp_colors: got %0d wrong want 0", color_errs); end
        checks++; if (start_busy_errs != 0) begin failures++; $display("FAIL bp_start_busy: got %0d want 0", start_busy_errs); end
    endtask

    task automatic test_same_cycle_done();
        bit to;
        do_reset();
        lat[0] = 6; lat[1] = 5;
        start_frame(32'h1000_0000, 32'h0, 32'h0100_0000);
        wait_done(800, to);
        checks++; if (to) begin failures++; $display("FAIL dual_timeout: got no frame_done want frame_done"); end
        checks++; if (!both_done) begin failures++; $display("FAIL dual_seen: got 0 want 1"); end
        checks++; if (pop_xq.size() < 2 || pop_xq[0] != 0 || pop_yq[0] != 0 || pop_xq[1] != 1 || pop_yq[1] != 0) begin failures++;
            $display("FAIL dual_order: got n=%0d want (0,0) then (1,0)", pop_xq.size()); end
        checks++; if (pop_cq.size() < 2 || pop_cq[1] - pop_cq[0] != 1) begin failures++;
            $display("FAIL dual_consecutive: got n=%0d want gap 1", pop_cq.size()); end
        checks++; if (bad_pixels() != 0) begin failures++; $display("FAIL dual_pixels: got %0d bad tags want 0", bad_pixels()); end
    endtask

    task automatic test_reset_midframe();
        bit to;
        do_reset();
        lat[0] = 5; lat[1] = 5;
        start_frame(32'h1000_0000, 32'h0, 32'h0100_0000);
        repeat (8) @(posedge sysclk);
        #1 reset = 1'b0;
        @(posedge sysclk); #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy: got %0b want 0", busy); end
        checks++; if (pix_valid !== 1'b0) begin failures++; $display("FAIL rmid_pix_valid: got %0b want 0", pix_valid); end
        checks++; if (eng_start !== 2'b00) begin failures++; $display("FAIL rmid_eng_start: got %b want 00", eng_start); end
        reset = 1'b1;
        repeat (30) @(posedge sysclk);
        #1;
        checks++; if (fd_cnt != 0) begin failures++; $display("FAIL rmid_no_done: got %0d want 0", fd_cnt); end
        start_frame(32'h1000_0000, 32'h0, 32'h0100_0000);
        wait_done(500, to);
        checks++; if (to) begin failures++; $display("FAIL rmid_timeout: got no frame_done want frame_done"); end
        checks++; if (bad_pixels() != 0) begin failures++; $display("FAIL rmid_pixels: got %0d bad tags want 0", bad_pixels()); end
        checks++; if (disp_re[3][2] !== 32'h1300_0000) begin failures++; $display("FAIL rmid_re_3_2: got %h want 13000000", disp_re[3][2]); end
    endtask

    task automatic test_restart_ignored();
        bit to;
        do_reset();
        lat[0] = 5; lat[1] = 5;
        start_frame(32'h1000_0000, 32'h0, 32'h0100_0000);
        repeat (3) @(posedge sysclk);
        #1;
        frame_start = 1'b1; re_origin = 32'h7000_0000; im_origin = 32'h0000_5555; step = 32'h10;
        @(posedge sysclk); #1;
        frame_start = 1'b0;
        wait_done(500, to);
        checks++; if (to) begin failures++; $display("FAIL rst2_timeout: got no frame_done want frame_done"); end
        checks++; if (disp_re[3][2] !== 32'h1300_0000) begin failures++; $display("FAIL rst2_re_3_2: got %h want 13000000", disp_re[3][2]); end
        checks++; if (disp_im[3][2] !== 32'hFE00_0000) begin failures++; $display("FAIL rst2_im_3_2: got %h want fe000000", disp_im[3][2]); end
        checks++; if (disp_re[0][1] !== 32'h1000_0000) begin failures++; $display("FAIL rst2_re_0_1: got %h want 10000000", disp_re[0][1]); end
        repeat (20) @(posedge sysclk);
        #1;
        checks++; if (fd_cnt != 1) begin failures++; $display("FAIL rst2_done_pulses: got %0d want 1", fd_cnt); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst2_idle: got busy=%0b want 0", busy); end
        checks++; if (bad_pixels() != 0) begin failures++; $display("FAIL rst2_pixels: got %0d bad tags want 0", bad_pixels()); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_out_of_order();
        test_backpressure();
        test_same_cycle_done();
        test_reset_midframe();
        test_restart_ignored();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
